prog_lut_mux: RTL and testbench
===============================

PROG_LUT_MUX -- requirements
Module: prog_lut_mux

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, legal range 2..6, giving the number of function inputs.
REQ-002 The block SHALL have derived constant TBL_W = 2**N_IN, giving truth-table depth in bits.
REQ-003 Port clk: input, 1 bit; single clock, all state updates on its rising edge.
REQ-004 Port rst_n: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port cfg_start: input, 1 bit; request a new truth-table load.
REQ-006 Port cfg_valid: input, 1 bit; cfg_bit is valid this cycle.
REQ-007 Port cfg_bit: input, 1 bit; serial truth-table bit, entry 0 first.
REQ-008 Port cfg_ready: output, 1 bit; block accepts cfg_bit.
REQ-009 Port cfg_done: output, 1 bit; one-cycle pulse when the new table is committed.
REQ-010 Port loaded: output, 1 bit; a valid table is held.
REQ-011 Port x: input, N_IN bits; function input vector.
REQ-012 Port x_valid: input, 1 bit; evaluate x this cycle.
REQ-013 Port sweep_start: input, 1 bit; request an exhaustive sweep of all TBL_W inputs.
REQ-014 Port sweep_busy: output, 1 bit; a sweep is in progress.
REQ-015 Port sweep_done: output, 1 bit; one-cycle pulse coincident with the last sweep result.
REQ-016 Port f: output, 1 bit; registered function result.
REQ-017 Port f_x: output, N_IN bits; input vector that produced f.
REQ-018 Port f_valid: output, 1 bit; f and f_x are valid this cycle.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD and SWEEP; reset state is IDLE.
REQ-020 In IDLE, cfg_start=1 SHALL move the FSM to LOAD and clear the bit counter; this applies regardless of loaded.
REQ-021 In IDLE, sweep_start=1 with loaded=1 and cfg_start=0 SHALL move the FSM to SWEEP and clear the sweep counter.
REQ-022 Simultaneous cfg_start and sweep_start in IDLE: cfg_start SHALL win and sweep_start SHALL be dropped.
REQ-023 In IDLE, sweep_start with loaded=0 SHALL be ignored.
REQ-024 cfg_ready SHALL be 1 exactly while in LOAD.
REQ-025 Each cycle with cfg_valid=1 and cfg_ready=1, cfg_bit SHALL be written into shadow[bit_cnt] and bit_cnt SHALL increment.
REQ-026 Cycles in LOAD with cfg_valid=0 SHALL hold state (no timeout).
REQ-027 On acceptance of bit TBL_W-1, at the next edge:
- shadow SHALL be copied atomically into the active table;
- loaded SHALL be set to 1;
- cfg_done SHALL pulse for one cycle;
- the FSM SHALL return to IDLE.
REQ-028 The active table SHALL never hold a partially loaded table.
REQ-029 cfg_start, sweep_start and x_valid SHALL be ignored while in LOAD.
REQ-030 Evaluation: x_valid=1 in IDLE with loaded=1 SHALL produce, one cycle later, f=table[x], f_x=x and f_valid=1.
REQ-031 x_valid with loaded=0 SHALL produce no f_valid.
REQ-032 Evaluation SHALL be fully pipelined, accepting back-to-back x_valid cycles.
REQ-033 SWEEP sequencing:
- sweep_busy SHALL be 1 while in SWEEP;
- each cycle the block SHALL issue count c = 0..TBL_W-1 in order;
- f=table[c], f_x=c and f_valid=1 SHALL appear one cycle after c is issued.
REQ-034 sweep_done SHALL pulse together with the result for c=TBL_W-1, and the FSM SHALL return to IDLE.
REQ-035 x_valid and all start requests SHALL be ignored during SWEEP.
REQ-036 The sweep counter SHALL be N_IN+1 bits wide so that termination does not rely on wrap-around.
REQ-037 When no result is valid, f_valid SHALL be 0, and f and f_x SHALL hold their previous values.

Reset
REQ-038 rst_n=0 SHALL immediately clear the following to 0: state (IDLE), counters, shadow, table, loaded, cfg_ready, cfg_done, sweep_busy, sweep_done, f, f_x and f_valid.
REQ-039 Reset mid-LOAD or mid-SWEEP SHALL abandon the operation with no pulse on cfg_done or sweep_done.
REQ-040 Reset SHALL leave loaded=0, so a full reload is required afterwards.

Structure
REQ-041 Package prog_lut_pkg SHALL hold the FSM state enum, the N_IN default and the TBL_W derivation.
REQ-042 Sub-module lut_mux_tree SHALL be a parametrised combinational TBL_W:1 multiplexer (table, select -> bit), shared by the evaluate and sweep paths.

Verification (N_IN=4)
REQ-043 Load 16'h8000, LSB first, with gaps in cfg_valid -> cfg_done pulses once after bit 15; loaded=1; then x=4'hF gives f=1 and x=4'hE gives f=0, each one cycle later.
REQ-044 Load 16'h6996, then sweep -> 16 consecutive f_valid cycles with f sequence 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0 and f_x 0..15; sweep_done only on f_x=15.
REQ-045 Sweep_start with loaded=0 -> no sweep_busy and no f_valid; cfg_start and sweep_start in the same cycle -> LOAD entered, no sweep.
REQ-046 Table 16'h8000 active, reload 16'hFFFF with x_valid x=4'h0 asserted mid-load -> no f_valid during the load; afterwards x=4'h0 gives f=1.
REQ-047 Assert rst_n=0 after 7 load bits or mid-sweep at f_x=5 -> outputs 0 immediately, no done pulse, loaded=0, x_valid ignored until a reload.

Source files
------------

// File: rtl/prog_lut_pkg.sv
// Shared definitions for the programmable look-up-table multiplexer.
// Holds the default number of function inputs, the truth-table depth
// derivation and the controller state encoding used by prog_lut_mux.
package prog_lut_pkg;

  localparam int N_IN_DEFAULT = 4;

  // Truth-table depth in bits for a function of n_in inputs (2**n_in).
  function automatic int tbl_w(input int n_in);
    return 1 << n_in;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } lut_state_e;

endpackage

// File: rtl/lut_mux_tree.sv
// Combinational 2**SEL_W : 1 multiplexer that picks one truth-table bit.
// Ports:
//   lut_bits - full truth table, entry 0 in bit 0
//   sel      - entry index
//   bit_out  - selected entry
module lut_mux_tree #(
  parameter int SEL_W = 4,
  localparam int DEPTH = 1 << SEL_W
) (
  input  logic [DEPTH-1:0] lut_bits,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_out
);

  assign bit_out = lut_bits[sel];

endmodule

// File: rtl/prog_lut_mux.sv
// Programmable N_IN-input boolean function built from a serially loaded
// truth table. A new table is shifted into a shadow register and only
// copied into the active table once complete, so evaluation never sees a
// half-written table. The active table can be evaluated for an external
// vector x, or swept exhaustively over all inputs.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   cfg_start/cfg_valid/cfg_bit    - table load request and serial data
//   cfg_ready/cfg_done/loaded      - load handshake, commit pulse, table held
//   x/x_valid                      - single evaluation request
//   sweep_start/sweep_busy/done    - exhaustive sweep control and status
//   f/f_x/f_valid                  - registered result and its input vector
module prog_lut_mux
  import prog_lut_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT,
  localparam int TBL_W = tbl_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            loaded,
  input  logic [N_IN-1:0] x,
  input  logic            x_valid,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            f,
  output logic [N_IN-1:0] f_x,
  output logic            f_valid
);

  localparam int CNT_W = N_IN + 1;
  localparam logic [N_IN-1:0]  BIT_LAST   = N_IN'(TBL_W - 1);
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(TBL_W - 1);

  lut_state_e       state_q, state_d;
  logic [N_IN-1:0]  bit_cnt_q;
  logic [CNT_W-1:0] sweep_cnt_q;
  logic [TBL_W-1:0] shadow_q, shadow_d;
  logic [TBL_W-1:0] table_q;
  logic             loaded_q;

  logic             accept;
  logic             last_bit;
  logic             start_load;
  logic             start_sweep;
  logic             eval_req;
  logic             sweep_issue;
  logic             sweep_last;
  logic [N_IN-1:0]  mux_sel;
  logic             mux_bit;

  assign cfg_ready  = (state_q == LOAD);
  assign sweep_busy = (state_q == SWEEP);
  assign loaded     = loaded_q;

  // Request decode. cfg_start has priority over sweep_start in IDLE, and
  // evaluation is only honoured in IDLE with a committed table. The shared
  // multiplexer select comes from the sweep counter during a sweep and from
  // x otherwise. shadow_d folds the incoming bit in, so the commit on the
  // last bit copies the complete table in one step.
  always_comb begin
    accept      = (state_q == LOAD) && cfg_valid;
    last_bit    = accept && (bit_cnt_q == BIT_LAST);
    start_load  = (state_q == IDLE) && cfg_start;
    start_sweep = (state_q == IDLE) && !cfg_start && sweep_start && loaded_q;
    eval_req    = (state_q == IDLE) && x_valid && loaded_q;
    sweep_issue = (state_q == SWEEP);
    sweep_last  = sweep_issue && (sweep_cnt_q == SWEEP_LAST);
    mux_sel     = sweep_issue ? sweep_cnt_q[N_IN-1:0] : x;
    shadow_d    = shadow_q;
    if (accept) begin
      shadow_d[bit_cnt_q] = cfg_bit;
    end
  end

  // Next-state logic. LOAD waits indefinitely for cfg_valid and leaves on
  // acceptance of the final bit; SWEEP leaves after issuing the last index.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD;
        end else if (start_sweep) begin
          state_d = SWEEP;
        end
      end
      LOAD: begin
        if (last_bit) begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (sweep_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, table storage and result registers. The sweep counter is one
  // bit wider than an index so the last-index compare never depends on
  // wrap-around. f and f_x hold their value whenever no result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      sweep_cnt_q <= '0;
      shadow_q    <= '0;
      table_q     <= '0;
      loaded_q    <= 1'b0;
      cfg_done    <= 1'b0;
      sweep_done  <= 1'b0;
      f           <= 1'b0;
      f_x         <= '0;
      f_valid     <= 1'b0;
    end else begin
      if (start_load) begin
        bit_cnt_q <= '0;
      end else if (accept) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (start_sweep) begin
        sweep_cnt_q <= '0;
      end else if (sweep_issue) begin
        sweep_cnt_q <= sweep_cnt_q + 1'b1;
      end

      shadow_q <= shadow_d;
      if (last_bit) begin
        table_q  <= shadow_d;
        loaded_q <= 1'b1;
      end

      cfg_done   <= last_bit;
      sweep_done <= sweep_last;
      f_valid    <= eval_req || sweep_issue;
      if (eval_req || sweep_issue) begin
        f   <= mux_bit;
        f_x <= mux_sel;
      end
    end
  end

  lut_mux_tree #(
    .SEL_W (N_IN)
  ) u_mux (
    .lut_bits (table_q),
    .sel      (mux_sel),
    .bit_out  (mux_bit)
  );

endmodule

// File: tb/tb_prog_lut_mux.sv
// Directed, self-checking bench for prog_lut_mux with N_IN = 4.
// Expected results are pushed to a scoreboard queue when a request is
// driven and popped by a monitor whenever the DUT raises f_valid.
module tb_prog_lut_mux;

  localparam int N_IN = 4;

  typedef struct packed {
    logic       f;
    logic [3:0] fx;
    logic       done;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_bit = 1'b0;
  logic            cfg_ready;
  logic            cfg_done;
  logic            loaded;
  logic [N_IN-1:0] x = '0;
  logic            x_valid = 1'b0;
  logic            sweep_start = 1'b0;
  logic            sweep_busy;
  logic            sweep_done;
  logic            f;
  logic [N_IN-1:0] f_x;
  logic            f_valid;

  exp_t        sb[$];
  exp_t        mon_e;
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] model_table = '0;
  logic        model_loaded = 1'b0;

  prog_lut_mux #(
    .N_IN (N_IN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .loaded      (loaded),
    .x           (x),
    .x_valid     (x_valid),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .f           (f),
    .f_x         (f_x),
    .f_valid     (f_valid)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Run-time guard so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [3:0] idx, input logic done);
    exp_t e;
    e.f    = model_table[idx];
    e.fx   = idx;
    e.done = done;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_f_valid"},    16'(f_valid),    16'd0);
    check_output({tag, "_f"},          16'(f),          16'd0);
    check_output({tag, "_f_x"},        16'(f_x),        16'd0);
    check_output({tag, "_loaded"},     16'(loaded),     16'd0);
    check_output({tag, "_cfg_ready"},  16'(cfg_ready),  16'd0);
    check_output({tag, "_cfg_done"},   16'(cfg_done),   16'd0);
    check_output({tag, "_sweep_busy"}, 16'(sweep_busy), 16'd0);
    check_output({tag, "_sweep_done"}, 16'(sweep_done), 16'd0);
  endtask

  // Scoreboard monitor: every f_valid must match the oldest expectation,
  // and a stray sweep_done without a result is reported.
  always @(negedge clk) begin
    if (rst_n && f_valid) begin
      if (sb.size() == 0) begin
        check_output("f_valid_unexpected", 16'(f_valid), 16'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("result_f",          16'(f),          16'(mon_e.f));
        check_output("result_f_x",        16'(f_x),        16'(mon_e.fx));
        check_output("result_sweep_done", 16'(sweep_done), 16'(mon_e.done));
      end
    end else if (rst_n && sweep_done) begin
      check_output("sweep_done_stray", 16'(sweep_done), 16'd0);
    end
  end

  task automatic load_table(input logic [15:0] value, input bit gaps,
                            input bit inject_x, input bit with_sweep);
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    cfg_start   = 1'b1;
    sweep_start = with_sweep;
    @(negedge clk);
    cfg_start   = 1'b0;
    sweep_start = 1'b0;
    check_output("load_cfg_ready", 16'(cfg_ready), 16'd1);
    check_output("load_no_sweep",  16'(sweep_busy), 16'd0);
    if (inject_x) begin
      x       = 4'h0;
      x_valid = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 4 == 2)) begin
        cfg_valid = 1'b0;
        @(negedge clk);
        done_seen += int'(cfg_done);
      end
      cfg_valid = 1'b1;
      cfg_bit   = value[i];
      @(negedge clk);
      done_seen += int'(cfg_done);
      if (i == 14) begin
        check_output("cfg_done_early", 16'(done_seen), 16'd0);
      end
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    x_valid   = 1'b0;
    check_output("cfg_done_pulse",       16'(cfg_done),  16'd1);
    check_output("loaded_after_load",    16'(loaded),    16'd1);
    check_output("cfg_ready_after_load", 16'(cfg_ready), 16'd0);
    model_table  = value;
    model_loaded = 1'b1;
    @(negedge clk);
    done_seen += int'(cfg_done);
    check_output("cfg_done_count", 16'(done_seen), 16'd1);
  endtask

  task automatic apply_stimulus(input logic [3:0] xv);
    logic expect_valid;
    @(negedge clk);
    x            = xv;
    x_valid      = 1'b1;
    expect_valid = model_loaded;
    if (model_loaded) begin
      sb.push_back(make_exp(xv, 1'b0));
    end
    @(negedge clk);
    x_valid = 1'b0;
    check_output("eval_latency", 16'(f_valid), 16'(expect_valid));
  endtask

  task automatic eval_burst(input logic [15:0] xs);
    logic [3:0] xv;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_output("burst_f_valid", 16'(f_valid), 16'd1);
      end
      xv      = xs[4*i +: 4];
      x       = xv;
      x_valid = 1'b1;
      sb.push_back(make_exp(xv, 1'b0));
    end
    @(negedge clk);
    x_valid = 1'b0;
    check_output("burst_f_valid_last", 16'(f_valid), 16'd1);
  endtask

  task automatic run_sweep(input int abort_at);
    logic expect_run;
    @(negedge clk);
    sweep_start = 1'b1;
    expect_run  = model_loaded;
    if (expect_run) begin
      for (int c = 0; c < 16; c++) begin
        sb.push_back(make_exp(4'(c), (c == 15)));
      end
    end
    @(negedge clk);
    sweep_start = 1'b0;
    check_output("sweep_busy_start", 16'(sweep_busy), 16'(expect_run));
    if (!expect_run) begin
      repeat (3) @(negedge clk);
      check_output("sweep_busy_ignored", 16'(sweep_busy), 16'd0);
      return;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cfg_start   = 1'b0;
      sweep_start = 1'b0;
      x_valid     = 1'b0;
      check_output("sweep_consecutive", 16'(f_valid), 16'd1);
      if (c == abort_at) begin
        check_output("sweep_abort_point", 16'(f_x), 16'(c));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("sweep_reset");
        sb.delete();
        model_loaded = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_output("sweep_reset_no_done", 16'(sweep_done), 16'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (c == 8) begin
        cfg_start   = 1'b1;
        sweep_start = 1'b1;
        x_valid     = 1'b1;
        x           = 4'hA;
      end
    end
    @(negedge clk);
    check_output("sweep_end_f_valid", 16'(f_valid),    16'd0);
    check_output("sweep_end_busy",    16'(sweep_busy), 16'd0);
    check_output("sweep_end_ready",   16'(cfg_ready),  16'd0);
  endtask

  // Linear directed sequence.
  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] sweep and evaluate with no table");
    run_sweep(-1);
    apply_stimulus(4'h3);

    $display("[TB] load 16'h8000 with gaps");
    load_table(16'h8000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(4'hF);
    apply_stimulus(4'hE);

    $display("[TB] load 16'h6996 with simultaneous sweep request, then sweep");
    load_table(16'h6996, 1'b0, 1'b0, 1'b1);
    run_sweep(-1);
    eval_burst(16'h0765);

    $display("[TB] reload 16'hFFFF with x_valid during load");
    load_table(16'h8000, 1'b0, 1'b0, 1'b0);
    load_table(16'hFFFF, 1'b1, 1'b1, 1'b0);
    apply_stimulus(4'h0);

    $display("[TB] reset after 7 load bits");
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("load_reset");
    model_loaded = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("load_reset_no_done", 16'(cfg_done), 16'd0);
    end
    rst_n = 1'b1;
    apply_stimulus(4'h0);
    run_sweep(-1);

    $display("[TB] reset mid-sweep at f_x=5");
    load_table(16'h6996, 1'b0, 1'b0, 1'b0);
    run_sweep(5);
    apply_stimulus(4'h1);
    check_output("loaded_after_sweep_reset", 16'(loaded), 16'd0);
    load_table(16'h8000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(4'hF);

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
